nor_exhaustive_tester: RTL and testbench



---
 rtl/nor_test_pkg.sv | 20 ++
 rtl/nor_hold_timer.sv | 28 ++
 rtl/nor_exhaustive_tester.sv | 117 +++++++++++
 tb/tb_nor_exhaustive_tester.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nor_test_pkg.sv
// Shared types and helpers for the four-input NOR exhaustive tester.
// State encoding, vector count and the expected gate response.
package nor_test_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int NUM_VECTORS = 16;

  // Expected NOR output: high only when every input is low
  function automatic logic exp_nor(
    input logic [3:0] v
  );
    return (v == 4'd0);
  endfunction

endpackage

// File: rtl/nor_hold_timer.sv
// Settle counter for one stimulus vector.
// expire marks the last cycle a vector is held before sampling.
module nor_hold_timer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expire
);

  logic [7:0] count;

  // Count settle cycles; clear wins over enable
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (en) begin
      count <= count + 8'd1;
    end
  end

  assign expire = (count == 8'(HOLD_CYCLES - 1));

endmodule

// File: rtl/nor_exhaustive_tester.sv
// Drives all 16 vectors into a 4-input NOR gate and checks e,f,g.
// Reports busy/done, pass, mismatch count and first failing vector.
module nor_exhaustive_tester
  import nor_test_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  input  logic       e,
  input  logic       f,
  input  logic       g,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic       err_e,
  output logic       err_f,
  output logic       err_g,
  output logic       first_err_valid,
  output logic [3:0] first_err_vec
);

  localparam logic [3:0] LAST_VEC = 4'(NUM_VECTORS - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] vec;
  logic       expire;
  logic       sample;
  logic       start_acc;
  logic [2:0] mism;
  logic       any_mism;
  logic [4:0] cnt_nxt;

  nor_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear ((state != DRIVE) || expire),
    .en    (state == DRIVE),
    .expire(expire)
  );

  assign sample    = (state == DRIVE) && expire;
  assign start_acc = start && (state != DRIVE);
  assign mism      = {e, f, g} ^ {3{exp_nor(vec)}};
  assign any_mism  = |mism;
  assign cnt_nxt   = (any_mism && (err_count < 5'd16))
                   ? err_count + 5'd1 : err_count;

  assign {a, b, c, d} = (state == DRIVE) ? vec : 4'd0;
  assign busy = (state == DRIVE);
  assign done = (state == DONE);

  // Next-state logic for the run sequencer
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (start) state_nxt = DRIVE;
      end
      DRIVE: begin
        if (sample && (vec == LAST_VEC)) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, vector and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      vec             <= 4'd0;
      pass            <= 1'b0;
      err_count       <= 5'd0;
      err_e           <= 1'b0;
      err_f           <= 1'b0;
      err_g           <= 1'b0;
      first_err_valid <= 1'b0;
      first_err_vec   <= 4'd0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        vec             <= 4'd0;
        pass            <= 1'b0;
        err_count       <= 5'd0;
        err_e           <= 1'b0;
        err_f           <= 1'b0;
        err_g           <= 1'b0;
        first_err_valid <= 1'b0;
        first_err_vec   <= 4'd0;
      end else if (sample) begin
        err_count <= cnt_nxt;
        err_e     <= err_e | mism[2];
        err_f     <= err_f | mism[1];
        err_g     <= err_g | mism[0];
        if (any_mism && !first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_vec   <= vec;
        end
        if (vec == LAST_VEC) begin
          pass <= (cnt_nxt == 5'd0);
        end else begin
          vec <= vec + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_nor_exhaustive_tester.sv
// Bench for nor_exhaustive_tester with a behavioural gate model.
// Covers good, faulty, random-fault, reset and H=1 runs.
module tb_nor_exhaustive_tester;

  localparam int H = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start;
  logic       a, b, c, d, e, f, g;
  logic       busy, done, pass;
  logic [4:0] err_count;
  logic       err_e, err_f, err_g;
  logic       first_err_valid;
  logic [3:0] first_err_vec;

  logic       start1;
  logic       a1, b1, c1, d1, e1, f1, g1;
  logic       busy1, done1, pass1;
  logic [4:0] err_count1;
  logic       err_e1, err_f1, err_g1;
  logic       first_err_valid1;
  logic [3:0] first_err_vec1;

  int          mode;
  logic [47:0] masks;
  int          checks = 0;
  int          errors = 0;

  int         m_cnt;
  logic [2:0] m_flags;
  logic       m_fvalid;
  logic [3:0] m_fvec;

  nor_exhaustive_tester #(.HOLD_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a(a), .b(b), .c(c), .d(d),
    .e(e), .f(f), .g(g),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count),
    .err_e(err_e), .err_f(err_f), .err_g(err_g),
    .first_err_valid(first_err_valid),
    .first_err_vec(first_err_vec)
  );

  nor_exhaustive_tester #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .a(a1), .b(b1), .c(c1), .d(d1),
    .e(e1), .f(f1), .g(g1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err_count1),
    .err_e(err_e1), .err_f(err_f1), .err_g(err_g1),
    .first_err_valid(first_err_valid1),
    .first_err_vec(first_err_vec1)
  );

  // Gate under test: good, stuck, d-ignored, inverted or random faults
  function automatic logic [2:0] gate_out(
    input int          m,
    input logic [3:0]  v,
    input logic [47:0] mk
  );
    logic n;
    n = ~|v;
    case (m)
      1: return {n, 1'b0, n};
      2: return {~|v[3:1], n, n};
      3: return {3{~n}};
      4: return {3{n}} ^ mk[int'(v) * 3 +: 3];
      default: return {3{n}};
    endcase
  endfunction

  assign {e, f, g} = gate_out(mode, {a, b, c, d}, masks);
  assign e1 = ~(a1 | b1 | c1 | d1);
  assign f1 = ~(a1 | b1 | c1 | d1);
  assign g1 = ~(a1 | b1 | c1 | d1);

  // Reference result: walk all vectors and compare gate to ideal NOR
  task automatic model(input int m);
    logic [2:0] o, x;
    m_cnt    = 0;
    m_flags  = 3'b000;
    m_fvalid = 1'b0;
    m_fvec   = 4'd0;
    for (int v = 0; v < 16; v++) begin
      o = gate_out(m, 4'(v), masks);
      x = o ^ ((v == 0) ? 3'b111 : 3'b000);
      if (x != 3'b000) begin
        m_cnt++;
        m_flags = m_flags | x;
        if (!m_fvalid) begin
          m_fvalid = 1'b1;
          m_fvec   = 4'(v);
        end
      end
    end
  endtask

  task automatic run(input string nm, input int m, input int pulse_at);
    mode = m;
    model(m);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 16 * H; k++) begin
      checks++;
      if ({a, b, c, d} !== 4'(k / H)) begin
        errors++;
        $display("FAIL %s vec k=%0d got %b want %b", nm, k,
                 {a, b, c, d}, 4'(k / H));
      end
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s busy/done k=%0d got %b%b want 10", nm, k,
                 busy, done);
      end
      if (k == 0) begin
        checks++;
        if (err_count !== 5'd0 || first_err_valid !== 1'b0 ||
            pass !== 1'b0) begin
          errors++;
          $display("FAIL %s clear got cnt=%0d fv=%b p=%b want 0", nm,
                   err_count, first_err_valid, pass);
        end
      end
      start = (k == pulse_at || k == pulse_at + 20);
      @(posedge clk);
      #1 start = 1'b0;
    end
    for (int r = 0; r < 2; r++) begin
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || {a, b, c, d} !== 4'd0) begin
        errors++;
        $display("FAIL %s end got done=%b busy=%b v=%b want 1 0 0000",
                 nm, done, busy, {a, b, c, d});
      end
      checks++;
      if (pass !== (m_cnt == 0)) begin
        errors++;
        $display("FAIL %s pass got %b want %b", nm, pass, m_cnt == 0);
      end
      checks++;
      if (err_count !== 5'(m_cnt)) begin
        errors++;
        $display("FAIL %s err_count got %0d want %0d", nm,
                 err_count, m_cnt);
      end
      checks++;
      if ({err_e, err_f, err_g} !== m_flags) begin
        errors++;
        $display("FAIL %s err_efg got %b want %b", nm,
                 {err_e, err_f, err_g}, m_flags);
      end
      checks++;
      if (first_err_valid !== m_fvalid || first_err_vec !== m_fvec) begin
        errors++;
        $display("FAIL %s first_err got %b/%0d want %b/%0d", nm,
                 first_err_valid, first_err_vec, m_fvalid, m_fvec);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_zero(input string nm);
    checks++;
    if ({a, b, c, d, busy, done, pass, err_count, err_e, err_f, err_g,
         first_err_valid, first_err_vec} !== 20'd0) begin
      errors++;
      $display("FAIL %s outputs got %h want 0", nm,
               {a, b, c, d, busy, done, pass, err_count, err_e, err_f,
                err_g, first_err_valid, first_err_vec});
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_zero("reset_with_start");
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1 check_zero("idle_after_reset");
  endtask

  task automatic test_good();
    run("good_h4_busy_pulses", 0, 10);
  endtask

  task automatic test_faults();
    run("f_stuck0", 1, -100);
    run("e_ignores_d", 2, -100);
    run("inverted", 3, -100);
    run("inverted_restart", 3, -100);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      for (int v = 0; v < 16; v++) begin
        masks[v * 3 +: 3] = ($urandom_range(0, 3) == 0)
                          ? 3'($urandom_range(1, 7)) : 3'd0;
      end
      run($sformatf("random_%0d", i), 4, -100);
    end
  endtask

  task automatic test_mid_reset();
    mode  = 3;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_zero("mid_run_reset");
    repeat (3) @(posedge clk);
    #1 check_zero("stays_idle");
  endtask

  task automatic test_h1();
    int cyc;
    start1 = 1'b1;
    @(posedge clk);
    cyc = 1;
    #1 start1 = 1'b0;
    while (!done1 && cyc < 40) begin
      @(posedge clk);
      cyc++;
      #1;
    end
    checks++;
    if (cyc !== 17) begin
      errors++;
      $display("FAIL h1_latency got %0d want 17", cyc);
    end
    checks++;
    if (pass1 !== 1'b1 || err_count1 !== 5'd0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL h1_result got p=%b cnt=%0d busy=%b want 1 0 0",
               pass1, err_count1, busy1);
    end
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    start1 = 1'b0;
    mode   = 0;
    masks  = '0;
    test_reset();
    test_good();
    test_faults();
    test_random();
    test_mid_reset();
    test_h1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
